// File: rtl/updown_cmd_ctrl.sv
// Button command controller: 2-flop sync, debounce and single-button arbiter per key.
// Define AUTO_REPEAT_EN to build the hold-to-repeat timer and REPEAT states.
module updown_cmd_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_inc_n,
  input  logic key_dec_n,
  output logic inc,
  output logic dec,
  output logic locked
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            inc_sync_p0, inc_sync_p1;
  logic            dec_sync_p0, dec_sync_p1;
  logic            inc_db_p2, dec_db_p2;
  logic [DB_W-1:0] inc_db_cnt, dec_db_cnt;
  logic            p_inc, p_dec;

  // Stage p0/p1: two-flop synchronisers, idle level is released (high)
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_sync_p0 <= 1'b1;
      inc_sync_p1 <= 1'b1;
      dec_sync_p0 <= 1'b1;
      dec_sync_p1 <= 1'b1;
    end else begin
      inc_sync_p0 <= key_inc_n;
      inc_sync_p1 <= inc_sync_p0;
      dec_sync_p0 <= key_dec_n;
      dec_sync_p1 <= dec_sync_p0;
    end
  end

  // Stage p2: debounced levels follow the synced level only after it stays different long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_db_p2  <= 1'b1;
      inc_db_cnt <= '0;
    end else if (inc_sync_p1 == inc_db_p2) begin
      inc_db_cnt <= '0;
    end else if (inc_db_cnt == DB_LAST) begin
      inc_db_p2  <= inc_sync_p1;
      inc_db_cnt <= '0;
    end else begin
      inc_db_cnt <= inc_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_db_p2  <= 1'b1;
      dec_db_cnt <= '0;
    end else if (dec_sync_p1 == dec_db_p2) begin
      dec_db_cnt <= '0;
    end else if (dec_db_cnt == DB_LAST) begin
      dec_db_p2  <= dec_sync_p1;
      dec_db_cnt <= '0;
    end else begin
      dec_db_cnt <= dec_db_cnt + 1'b1;
    end
  end

  assign p_inc = ~inc_db_p2;
  assign p_dec = ~dec_db_p2;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, HOLD_INC, HOLD_DEC, REPEAT_INC, REPEAT_DEC, LOCK} state_t;
  logic [TMR_W-1:0] timer;
`else
  typedef enum logic [1:0] {IDLE, HOLD_INC, HOLD_DEC, LOCK} state_t;
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  state_t state;

  // Stage p3: arbiter; first key owns the strobes, a second key only forces LOCK
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      inc    <= 1'b0;
      dec    <= 1'b0;
      locked <= 1'b0;
`ifdef AUTO_REPEAT_EN
      timer  <= '0;
`endif
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state)
        IDLE: begin
          if (p_inc && p_dec) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (p_inc) begin
            state <= HOLD_INC;
            inc   <= 1'b1;
          end else if (p_dec) begin
            state <= HOLD_DEC;
            dec   <= 1'b1;
          end
        end
        HOLD_INC: begin
          if (p_dec) begin
            state  <= LOCK;
            locked <= 1'b1;
`ifdef AUTO_REPEAT_EN
            timer  <= '0;
`endif
          end else if (!p_inc) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
            timer <= '0;
          end else if (timer == DLY_LAST) begin
            state <= REPEAT_INC;
            inc   <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
        HOLD_DEC: begin
          if (p_inc) begin
            state  <= LOCK;
            locked <= 1'b1;
`ifdef AUTO_REPEAT_EN
            timer  <= '0;
`endif
          end else if (!p_dec) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
            timer <= '0;
          end else if (timer == DLY_LAST) begin
            state <= REPEAT_DEC;
            dec   <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        REPEAT_INC: begin
          if (p_dec) begin
            state  <= LOCK;
            locked <= 1'b1;
            timer  <= '0;
          end else if (!p_inc) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == PER_LAST) begin
            inc   <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT_DEC: begin
          if (p_inc) begin
            state  <= LOCK;
            locked <= 1'b1;
            timer  <= '0;
          end else if (!p_dec) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == PER_LAST) begin
            dec   <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        LOCK: begin
          if (!p_inc && !p_dec) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_cmd_ctrl.sv
// Randomised and scenario bench for updown_cmd_ctrl against a cycle-level behavioural model.
module tb_updown_cmd_ctrl;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  localparam int M_FREE     = 0;
  localparam int M_OWN_INC  = 1;
  localparam int M_OWN_DEC  = 2;
  localparam int M_CONFLICT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_inc_n = 1'b1;
  logic key_dec_n = 1'b1;
  logic inc, dec, locked;

  always #5 clk = ~clk;

  updown_cmd_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_inc_n(key_inc_n),
    .key_dec_n(key_dec_n),
    .inc(inc),
    .dec(dec),
    .locked(locked)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lock_cyc = -1;
  int inc_cycles[$];
  int dec_cycles[$];

  // behavioural model state
  bit m_inc, m_dec, m_locked;
  bit deb_i = 1'b1, deb_d = 1'b1;
  int run_i = 0, run_d = 0;
  bit hist_i[$], hist_d[$];
  int mode = M_FREE;
  int held = 0;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit strobe_due(int n);
`ifdef AUTO_REPEAT_EN
    return (n == RD) || (n > RD && ((n - RD) % RP) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic deb_step(inout bit deb, inout int run, input bit synced);
    if (synced != deb) begin
      run++;
      if (run == DB) begin
        deb = synced;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_update(input bit rst, input bit ki, input bit kd);
    bit pi, pd;
    if (rst) begin
      m_inc = 0; m_dec = 0; m_locked = 0;
      deb_i = 1; deb_d = 1; run_i = 0; run_d = 0;
      hist_i.delete(); hist_d.delete();
      hist_i.push_back(1'b1); hist_i.push_back(1'b1);
      hist_d.push_back(1'b1); hist_d.push_back(1'b1);
      mode = M_FREE; held = 0;
    end else begin
      pi = !deb_i;
      pd = !deb_d;
      m_inc = 0;
      m_dec = 0;
      case (mode)
        M_FREE: begin
          if (pi && pd) mode = M_CONFLICT;
          else if (pi) begin mode = M_OWN_INC; held = 0; m_inc = 1; end
          else if (pd) begin mode = M_OWN_DEC; held = 0; m_dec = 1; end
        end
        M_OWN_INC: begin
          if (pd) mode = M_CONFLICT;
          else if (!pi) mode = M_FREE;
          else begin held++; m_inc = strobe_due(held); end
        end
        M_OWN_DEC: begin
          if (pi) mode = M_CONFLICT;
          else if (!pd) mode = M_FREE;
          else begin held++; m_dec = strobe_due(held); end
        end
        default: if (!pi && !pd) mode = M_FREE;
      endcase
      m_locked = (mode == M_CONFLICT);
      deb_step(deb_i, run_i, hist_i[0]);
      deb_step(deb_d, run_d, hist_d[0]);
      void'(hist_i.pop_front()); hist_i.push_back(ki);
      void'(hist_d.pop_front()); hist_d.push_back(kd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(reset, key_inc_n, key_dec_n);
    cyc++;
    @(negedge clk);
    chk("inc", int'(inc), int'(m_inc));
    chk("dec", int'(dec), int'(m_dec));
    chk("locked", int'(locked), int'(m_locked));
    chk("inc_dec_excl", int'(inc & dec), 0);
    if (inc) inc_cycles.push_back(cyc);
    if (dec) dec_cycles.push_back(cyc);
    if (locked && lock_cyc < 0) lock_cyc = cyc;
  endtask

  task automatic do_reset();
    key_inc_n = 1'b1;
    key_dec_n = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_locked", int'(locked), 0);
    reset = 1'b0;
    cyc = 0;
    lock_cyc = -1;
    inc_cycles.delete();
    dec_cycles.delete();
  endtask

  initial begin
    int li, ld;
    @(negedge clk);

    // single press, exactly one strobe
    do_reset();
    while (cyc < 40) begin
      key_inc_n = !(cyc >= 10 && cyc < 22);
      tick();
    end
    chk("t1_inc_count", inc_cycles.size(), 1);
    chk("t1_inc_cycle", (inc_cycles.size() > 0) ? inc_cycles[0] : -1, 17);
    chk("t1_dec_count", dec_cycles.size(), 0);

    // bounce shorter than debounce window
    do_reset();
    while (cyc < 40) begin
      key_dec_n = (cyc < 20) ? ((cyc / 2) % 2 == 1) : 1'b1;
      tick();
    end
    chk("t2_dec_count", dec_cycles.size(), 0);
    chk("t2_locked", lock_cyc, -1);

    // long hold
    do_reset();
    while (cyc < 90) begin
      key_inc_n = !(cyc >= 10 && cyc < 70);
      tick();
    end
    chk("t3_first", (inc_cycles.size() > 0) ? inc_cycles[0] : -1, 17);
`ifdef AUTO_REPEAT_EN
    chk("t3_second", (inc_cycles.size() > 1) ? inc_cycles[1] : -1, 37);
    chk("t3_third", (inc_cycles.size() > 2) ? inc_cycles[2] : -1, 42);
`else
    chk("t3_count", inc_cycles.size(), 1);
`endif

    // first key wins, second forces lock
    do_reset();
    while (cyc < 90) begin
      key_inc_n = !(cyc >= 10 && cyc < 60);
      key_dec_n = !(cyc >= 30 && cyc < 60);
      tick();
    end
    chk("t4_inc_count", inc_cycles.size(), 1);
    chk("t4_inc_cycle", (inc_cycles.size() > 0) ? inc_cycles[0] : -1, 17);
    chk("t4_lock_cycle", lock_cyc, 37);
    chk("t4_dec_count", dec_cycles.size(), 0);
    chk("t4_locked_end", int'(locked), 0);

    // simultaneous press
    do_reset();
    while (cyc < 40) begin
      key_inc_n = !(cyc >= 10);
      key_dec_n = !(cyc >= 10);
      tick();
    end
    chk("t5_lock_cycle", lock_cyc, 17);
    chk("t5_strobes", inc_cycles.size() + dec_cycles.size(), 0);

    // reset while held
    do_reset();
    while (cyc < 50) begin
      key_dec_n = !(cyc >= 10);
      reset = (cyc == 25);
      tick();
    end
    reset = 1'b0;
    chk("t6_dec_count", dec_cycles.size(), 2);
    chk("t6_dec_first", (dec_cycles.size() > 0) ? dec_cycles[0] : -1, 17);
    chk("t6_dec_second", (dec_cycles.size() > 1) ? dec_cycles[1] : -1, 33);

    // random segments with occasional reset pulses
    do_reset();
    li = 0;
    ld = 0;
    repeat (4000) begin
      if (li == 0) begin
        key_inc_n = $urandom_range(0, 1);
        li = $urandom_range(1, 45);
      end
      if (ld == 0) begin
        key_dec_n = $urandom_range(0, 1);
        ld = $urandom_range(1, 45);
      end
      li--;
      ld--;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
